// File: rtl/battery_manager.sv
// Battery charge model and fan-power gate: drains or recharges a 0..MAX_LEVEL
// percentage on a 1 s timebase and grants the fan speed the battery can supply.
module battery_manager #(
  parameter int TICK_DIV   = 100,
  parameter int INIT_LEVEL = 99,
  parameter int MAX_LEVEL  = 99,
  parameter int DRAIN_S1   = 4,
  parameter int DRAIN_S2   = 2,
  parameter int DRAIN_S3   = 1,
  parameter int CHARGE_S   = 1,
  parameter int LOW_THRESH = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] fan_req,
  input  logic       charger_connected,
  output logic [1:0] fan_state,
  output logic [7:0] battery_level,
  output logic       battery_empty,
  output logic       low_battery
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {DISCHARGE, CHARGE, EMPTY} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic [7:0]    sec_cnt, sec_nxt, sec_inc;
  logic [7:0]    level_nxt, drain_period;
  logic [1:0]    fan_nxt;
  logic          empty_nxt, low_nxt;
  logic          req_changed, drain_due;

  assign tick        = (prescaler == PW'(TICK_DIV - 1));
  assign sec_inc     = sec_cnt + 8'd1;
  assign req_changed = (fan_req != fan_state);

  always_comb begin
    case (fan_req)
      2'd1:    drain_period = 8'(DRAIN_S1);
      2'd2:    drain_period = 8'(DRAIN_S2);
      default: drain_period = 8'(DRAIN_S3);
    endcase
  end

  // A drop is due only when the request is stable, non-zero and its period completes.
  assign drain_due = tick && (fan_req != 2'd0) && !req_changed && (sec_inc == drain_period);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_nxt = state;
    sec_nxt   = sec_cnt;
    level_nxt = battery_level;
    fan_nxt   = fan_req;
    empty_nxt = 1'b0;
    case (state)
      DISCHARGE: begin
        if (charger_connected) begin
          state_nxt = CHARGE;
          sec_nxt   = '0;
          // The only drop that survives a transition is the one that would empty the cell.
          if (drain_due && battery_level == 8'd1) level_nxt = '0;
        end else if (fan_req == 2'd0 || req_changed) begin
          sec_nxt = '0;
        end else if (drain_due) begin
          sec_nxt   = '0;
          level_nxt = battery_level - 8'd1;
          if (battery_level == 8'd1) state_nxt = EMPTY;
        end else if (tick) begin
          sec_nxt = sec_inc;
        end
      end
      CHARGE: begin
        if (!charger_connected) begin
          state_nxt = (battery_level != 8'd0) ? DISCHARGE : EMPTY;
          sec_nxt   = '0;
        end else if (req_changed) begin
          sec_nxt = '0;
        end else if (tick) begin
          if (sec_inc == 8'(CHARGE_S)) begin
            sec_nxt = '0;
            if (battery_level < 8'(MAX_LEVEL)) level_nxt = battery_level + 8'd1;
          end else begin
            sec_nxt = sec_inc;
          end
        end
      end
      EMPTY: begin
        fan_nxt   = 2'd0;
        sec_nxt   = '0;
        level_nxt = '0;
        if (charger_connected) state_nxt = CHARGE;
        else                   empty_nxt = 1'b1;
      end
      default: begin
        state_nxt = DISCHARGE;
        sec_nxt   = '0;
      end
    endcase
  end

  // The warning is suppressed while the charger is supplying the fan.
  assign low_nxt = (level_nxt <= 8'(LOW_THRESH)) && (state_nxt != CHARGE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler     <= '0;
      sec_cnt       <= '0;
      state         <= DISCHARGE;
      fan_state     <= 2'd0;
      battery_level <= 8'(INIT_LEVEL);
      battery_empty <= 1'b0;
      low_battery   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      prescaler     <= tick ? '0 : prescaler + PW'(1);
      sec_cnt       <= sec_nxt;
      state         <= state_nxt;
      fan_state     <= fan_nxt;
      battery_level <= level_nxt;
      battery_empty <= empty_nxt;
      low_battery   <= low_nxt;
    end
  end

endmodule

// File: tb/tb_battery_manager.sv
// Randomized and directed stimulus for battery_manager, checked through a
// scoreboard fed by a behavioural battery model.
module tb_battery_manager;

  localparam int TD   = 4;
  localparam int INIT = 99;
  localparam int MAXL = 99;
  localparam int D1   = 4;
  localparam int D2   = 2;
  localparam int D3   = 1;
  localparam int CS   = 1;
  localparam int LOW  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] fan_req = 2'd0;
  logic       charger_connected = 1'b0;
  logic [1:0] fan_state;
  logic [7:0] battery_level;
  logic       battery_empty;
  logic       low_battery;

  battery_manager #(
    .TICK_DIV(TD), .INIT_LEVEL(INIT), .MAX_LEVEL(MAXL), .DRAIN_S1(D1),
    .DRAIN_S2(D2), .DRAIN_S3(D3), .CHARGE_S(CS), .LOW_THRESH(LOW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fan_req(fan_req), .charger_connected(charger_connected),
    .fan_state(fan_state), .battery_level(battery_level),
    .battery_empty(battery_empty), .low_battery(low_battery)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fan;
    int level;
    int empty;
    int low;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: battery as a plain percentage plus charger/exhausted flags.
  int m_pre, m_sec, m_level, m_fan, m_empty_out;
  bit m_on_charger, m_dead;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int period_of(input int fr);
    if (fr == 1) return D1;
    if (fr == 2) return D2;
    return D3;
  endfunction

  task automatic model_reset();
    m_pre = 0; m_sec = 0; m_level = INIT; m_fan = 0; m_empty_out = 0;
    m_on_charger = 1'b0; m_dead = 1'b0;
  endtask

  task automatic model_step(input int fr, input int ch);
    bit tick;
    bit due;
    int per;
    tick  = (m_pre == TD - 1);
    per   = period_of(fr);
    m_pre = (m_pre + 1) % TD;
    if (m_dead) begin
      m_fan = 0;
      m_sec = 0;
      if (ch != 0) begin
        m_dead = 1'b0; m_on_charger = 1'b1; m_empty_out = 0;
      end else begin
        m_empty_out = 1;
      end
    end else if (m_on_charger) begin
      m_empty_out = 0;
      if (ch == 0) begin
        m_on_charger = 1'b0; m_dead = (m_level == 0); m_sec = 0;
      end else if (fr != m_fan) begin
        m_sec = 0;
      end else if (tick) begin
        m_sec++;
        if (m_sec == CS) begin
          m_sec = 0;
          m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
        end
      end
      m_fan = fr;
    end else begin
      due = tick && fr != 0 && fr == m_fan && (m_sec + 1 == per);
      if (ch != 0) begin
        m_on_charger = 1'b1; m_sec = 0;
        if (due && m_level == 1) m_level = 0;
      end else if (fr == 0 || fr != m_fan) begin
        m_sec = 0;
      end else if (due) begin
        m_sec = 0; m_level--; m_dead = (m_level == 0);
      end else if (tick) begin
        m_sec++;
      end
      m_fan = fr;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.fan   = m_fan;
    e.level = m_level;
    e.empty = m_empty_out;
    e.low   = (m_level <= LOW && !m_on_charger) ? 1 : 0;
    sb_q.push_back(e);
  endtask

  // Advance n clock edges; inputs change 1 time unit after each edge.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step(int'(fan_req), int'(charger_connected));
      push_expect();
      #1;
    end
  endtask

  task automatic run_until_level(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (m_level != target && k < budget) begin
      cyc();
      k++;
    end
    if (m_level != target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: cycle budget expired, level %0d required %0d", name, m_level, target);
    end
  endtask

  // Leaves the bench just before an edge on which the prescaler ticks.
  task automatic align_to_tick();
    for (int i = 0; i < TD && m_pre != TD - 1; i++) cyc();
  endtask

  task automatic pulse_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    sb_q.delete();
    push_expect();
    cyc(2);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("fan_state",     int'(fan_state),     mon_e.fan);
      check("battery_level", int'(battery_level), mon_e.level);
      check("battery_empty", int'(battery_empty), mon_e.empty);
      check("low_battery",   int'(low_battery),   mon_e.low);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;

    fan_req = 2'd0; cyc(40);
    fan_req = 2'd3; cyc(30);
    fan_req = 2'd1; cyc(40);

    // Request change landing on a tick must not move the level.
    fan_req = 2'd2; cyc(6);
    align_to_tick();
    fan_req = 2'd3; cyc(10);

    // Drain to exhaustion, then ignore the request while empty.
    run_until_level(0, 600, "drain_to_empty");
    fan_req = 2'd2; cyc(100);

    // Recovery and both charger-release outcomes.
    charger_connected = 1'b1;
    run_until_level(1, 40, "charge_to_1");
    charger_connected = 1'b0; cyc(2);
    run_until_level(0, 40, "drain_again");
    cyc(3);
    charger_connected = 1'b1; cyc(1);
    charger_connected = 1'b0; cyc(6);

    // Charge to saturation and hold there.
    charger_connected = 1'b1; fan_req = 2'd1;
    run_until_level(98, 600, "charge_to_98");
    cyc(TD * 12);

    // Charger arrives on the edge that would empty the battery.
    charger_connected = 1'b0; fan_req = 2'd3;
    run_until_level(1, 600, "drain_to_1");
    align_to_tick();
    charger_connected = 1'b1; cyc(1);
    cyc(TD * 3);

    for (int s = 0; s < 60; s++) begin
      fan_req           = 2'($urandom_range(0, 3));
      charger_connected = ($urandom_range(0, 3) == 0);
      cyc(int'($urandom_range(1, 40)));
    end

    // Asynchronous reset in the middle of a drain.
    charger_connected = 1'b1;
    run_until_level(99, 600, "charge_to_99");
    charger_connected = 1'b0; fan_req = 2'd3;
    run_until_level(50, 600, "drain_to_50");
    cyc(1);
    pulse_reset();
    fan_req = 2'd2; cyc(30);

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/battery_manager.md
Name: battery_manager

Overview:
- Battery model and fan-power gate for the fan controller.
- Takes the requested fan speed from the key/mode logic and the charger-present input.
- Maintains battery charge as a percentage (0..99) and drains or recharges it at per-speed rates on a 1 s timebase.
- Outputs the granted fan_state, battery_level and battery_empty that directly drive the seven-segment display stage and the motor PWM.

Parameters:
TICK_DIV, 100, clk cycles per 1 s tick (100 Hz system clock)
INIT_LEVEL, 99, battery_level after reset
MAX_LEVEL, 99, charge saturation value
DRAIN_S1, 4, seconds per 1% drop at fan_state 1
DRAIN_S2, 2, seconds per 1% drop at fan_state 2
DRAIN_S3, 1, seconds per 1% drop at fan_state 3
CHARGE_S, 1, seconds per 1% rise while charging
LOW_THRESH, 20, low_battery asserted when level <= this

Ports:
clk  input  1  system clock, 100 Hz
rst_n  input  1  asynchronous, active-low reset
fan_req  input  2  requested speed, 0=off, 1..3 = speeds; already synchronous/debounced
charger_connected  input  1  charger present, synchronous level
fan_state  output  2  granted speed, registered
battery_level  output  8  charge percent 0..MAX_LEVEL, binary, registered
battery_empty  output  1  battery exhausted, registered
low_battery  output  1  low-charge warning, registered

Behaviour:
- Reset is asynchronous, active-low, on clock clk. Reset values:
  - fan_state = 0
  - battery_level = INIT_LEVEL
  - battery_empty = 0
  - low_battery = 0
  - prescaler = 0, sec_cnt = 0
  - FSM = DISCHARGE
- Prescaler runs free from 0 to TICK_DIV-1 and wraps. `tick` is a 1-cycle pulse in the cycle where the count equals TICK_DIV-1. Tick phase is never reset by state or request changes.
- sec_cnt is 8 bits and counts ticks toward the active period. All periods must be in 1..255; sec_cnt never wraps.
- Active period by state:
  - DISCHARGE: DRAIN_Sx for the current fan_req.
  - CHARGE: CHARGE_S.
- FSM states: DISCHARGE, CHARGE, EMPTY.
- DISCHARGE:
  - fan_state <= fan_req.
  - fan_req = 0: no drain, sec_cnt held at 0.
  - Otherwise, on tick: sec_cnt+1. When sec_cnt+1 equals the period, battery_level decrements by 1 and sec_cnt clears.
  - A decrement that produces 0 moves to EMPTY in the same clock edge.
  - charger_connected = 1 → CHARGE.
- EMPTY:
  - fan_state forced 0 and battery_empty = 1, both registered one cycle after the level reaches 0.
  - battery_level holds 0. fan_req is ignored.
  - charger_connected = 1 → CHARGE, and battery_empty clears on that edge.
- CHARGE:
  - fan_state <= fan_req; the fan runs from the charger, so there is no drain.
  - On tick: sec_cnt+1. At the CHARGE_S period, battery_level+1, saturating at MAX_LEVEL (holds, no wrap).
  - charger_connected = 0 → DISCHARGE if battery_level > 0, else EMPTY.
- sec_cnt clears on:
  - every FSM transition;
  - any cycle where fan_req differs from the registered fan_state (DISCHARGE and CHARGE only).
  Partial progress is discarded.
- Simultaneous events:
  - Transition or fan_req change in the same cycle as tick: the transition/clear wins and there is no level change that cycle.
  - Charger connect in the same cycle that the level would reach 0: go to CHARGE, level decrements to 0, battery_empty stays 0.
- low_battery is registered: 1 when next battery_level <= LOW_THRESH and next state is not CHARGE.
- battery_level is always <= MAX_LEVEL, so it is safe for the display's divide-by-10 decoding.
- Reset asserted mid-operation restores all reset values immediately (asynchronous); the first tick comes TICK_DIV cycles after release.

Test Plan:
- Reset/idle (TICK_DIV=4, INIT_LEVEL=99), fan_req=0 for 40 cycles → level stays 99, fan_state=0, battery_empty=0, low_battery=0.
- Drain rates: fan_req=3 → level drops by 1 every 4 cycles (99→98 after the first tick). Switch to fan_req=1 → sec_cnt clears, next drop after 4 ticks = 16 cycles.
- Exhaustion: INIT_LEVEL=2, fan_req=2 → level 1 after 2 ticks, 0 after 4 ticks. Next cycle battery_empty=1 and fan_state=0 with fan_req still 2. Level stays 0 for 100 cycles.
- Recovery: from EMPTY, assert charger_connected → battery_empty=0 next cycle, fan_state follows fan_req, level 0→1 after 1 tick. Release charger at level 1 → DISCHARGE. Release at level 0 → EMPTY.
- Saturation/low warning: charge from 98 → 99, then holds 99 for 10 ticks. Drain from 21 → low_battery rises with level 20, and is forced 0 while charging.
- Corner cases:
  - Tick coincident with a fan_req change → no decrement that cycle.
  - rst_n pulsed low mid-drain at level 50 → level 99 and fan_state 0 asynchronously.
